pong_ball_ctrl: RTL
===================

# pong_ball_ctrl

Ball physics and scoring engine for the Pong game. Owns the authoritative ball position: it advances the ball once per game tick, bounces it off the top/bottom walls and both paddle faces, and detects misses. It consumes both paddle positions and produces the ball position that the AI paddle controller, the renderer and the score display read. It also runs the serve delay and game-over sequencing.

## Interface
- TICK_DIV, 2097152: clocks per game tick; ≥2.
- SERVE_TICKS, 60: ticks the ball rests at center before launch; ≥1.
- WIN_SCORE, 7: winning score; 1..15.
- LEFT_BOUND, 16; RIGHT_BOUND, 624; TOP_BOUND, 40; BOTTOM_BOUND, 464: playfield edges, in pixels.
- PADDLE_WIDTH, 8; PADDLE_HEIGHT, 60; BALL_RADIUS, 4.
- SPEED_H, 3; SPEED_V, 2: pixels per tick.
- clk in 1: system clock.
- rst in 1: synchronous, active-high reset.
- pause in 1: while high, ticks are suppressed. The divider still runs.
- p1_pos_v in 10: top edge of the left paddle.
- p2_pos_v in 10: top edge of the right paddle.
- ball_pos_h out 10: ball center, horizontal.
- ball_pos_v out 10: ball center, vertical.
- score_p1 out 4, score_p2 out 4: current scores.
- game_over out 1: level signal; high in GAME_OVER.
- hit_p1, hit_p2 out 1: one-clk pulse on a paddle return.
- point_p1, point_p2 out 1: one-clk pulse when that player scores.

## Operation
- Derived constants:
  - CH = (LEFT_BOUND+RIGHT_BOUND)/2 = 320.
  - CV = (TOP_BOUND+BOTTOM_BOUND)/2 = 252.
  - LF = LEFT_BOUND+PADDLE_WIDTH = 24.
  - RF = RIGHT_BOUND−PADDLE_WIDTH = 616.
- Tick: the divider counts 0..TICK_DIV−1 and wraps. tick = (count==TICK_DIV−1) && !pause. All state changes occur only on tick cycles.
- Direction regs: dir_h (1 = right) and dir_v (1 = down).
- State SERVE:
  - Ball is held at (CH,CV).
  - serve_cnt increments each tick.
  - On the tick where serve_cnt==SERVE_TICKS−1: clear serve_cnt and go to PLAY. Position does not change on that tick.
- State PLAY, each tick, using the pre-tick position (h,v):
  - Vertical:
    - If dir_v=1 and v+R+SPEED_V ≥ BOTTOM_BOUND: v←BOTTOM_BOUND−R, dir_v←0.
    - Else if dir_v=0 and v ≤ TOP_BOUND+R+SPEED_V: v←TOP_BOUND+R, dir_v←1.
    - Else v←v±SPEED_V.
  - Right edge (dir_h=1 and h+R+SPEED_H ≥ RF):
    - Overlap test: v+R ≥ p2_pos_v and v ≤ p2_pos_v+PADDLE_HEIGHT+R.
    - Overlap: h←RF−R, dir_h←0, pulse hit_p2.
    - No overlap: miss; player 1 scores.
  - Left edge (dir_h=0 and h ≤ LF+R+SPEED_H):
    - Same overlap test, against p1_pos_v.
    - Overlap: h←LF+R, dir_h←1, pulse hit_p1.
    - No overlap: miss; player 2 scores.
  - Otherwise h←h±SPEED_H.
  - The vertical and horizontal updates are independent. A corner hit applies both on the same tick.
- Miss handling (same tick):
  - Increment the scorer's score and pulse point_pX.
  - Ball returns to (CH,CV).
  - dir_h points toward the player who conceded. dir_v toggles from its value at the miss.
  - If the new score equals WIN_SCORE, go to GAME_OVER; otherwise go to SERVE.
  - A miss overrides that tick's wall update.
- State GAME_OVER:
  - Ball frozen at center; scores held; game_over=1.
  - Exit only via rst.
- Arithmetic:
  - All comparisons are in 11-bit unsigned, written in add-only form, so there is no underflow.
  - Scores never wrap because WIN_SCORE ≤ 15.
- Reset values:
  - State SERVE, divider and serve_cnt 0.
  - Ball (CH,CV), dir_h=1, dir_v=1.
  - Scores 0, game_over 0, all pulses 0.

## Timing
- All outputs are registered. They update on the clk edge that ends a tick cycle, and are visible the following cycle.
- Pulses are high for exactly one clk, aligned with the position update that caused them.
- Paddle inputs are sampled only on tick cycles. No synchronization is needed: they share clk.
- First motion after reset occurs on tick SERVE_TICKS+1, i.e. (SERVE_TICKS+1)·TICK_DIV clocks after rst falls.
- pause affects the tick only; reset has priority over pause.
- rst asserted mid-PLAY: on the next edge, all reset values are restored regardless of tick.

## Test plan
- Bench uses TICK_DIV=4, SERVE_TICKS=2, other parameters at default.
- Reset/serve: release rst → ball (320,252), scores 0. Ball is still at center after tick 2. Tick 3 → (323,254).
- Right paddle hit: hold p2_pos_v=420. Movement tick 98 sees pre-state (611,446) → ball (612,448), dir left, hit_p2 high for 1 clk.
- Bottom wall: continue from the previous scenario. Movement tick 104 (pre v=458) → v=460, dir up. h continues decreasing by 3.
- Miss/score: hold p2_pos_v=40. Movement tick 98 → score_p1=1, point_p1 pulse, ball (320,252), state SERVE, next launch rightward and upward.
- Game over and pause:
  - Set WIN_SCORE=2, p2_pos_v=40. After the second miss: game_over=1, score_p1=2, ball stays at (320,252) for 1000 clks.
  - pause held high in PLAY → position unchanged.
- Reset mid-play: assert rst for one cycle at a PLAY tick → next cycle shows all reset values, and no pulse is emitted.

Source files
------------

// File: rtl/pong_ball_ctrl.sv
// ============================================================================
// pong_ball_ctrl
// ----------------------------------------------------------------------------
// Ball physics and scoring engine for Pong. Owns the authoritative ball
// position. Once per game tick it moves the ball. It bounces the ball off the
// top and bottom walls and off both paddle faces, and it detects misses. It
// also sequences the serve delay, the scoring and the final game-over state.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous, active-high reset
//   pause      in   suppresses game ticks while high (divider keeps running)
//   p1_pos_v   in   [9:0] top edge of the left paddle
//   p2_pos_v   in   [9:0] top edge of the right paddle
//   ball_pos_h out  [9:0] ball centre, horizontal
//   ball_pos_v out  [9:0] ball centre, vertical
//   score_p1   out  [3:0] left player score
//   score_p2   out  [3:0] right player score
//   game_over  out  level, high once a player has reached WIN_SCORE
//   hit_p1     out  one-clk pulse when the left paddle returns the ball
//   hit_p2     out  one-clk pulse when the right paddle returns the ball
//   point_p1   out  one-clk pulse when the left player scores
//   point_p2   out  one-clk pulse when the right player scores
//
// All outputs are registered. They change only on the edge that ends a tick
// cycle, except for reset, which takes effect on the next edge.
// ============================================================================
module pong_ball_ctrl #(
    parameter int unsigned TICK_DIV      = 2097152,
    parameter int unsigned SERVE_TICKS   = 60,
    parameter int unsigned WIN_SCORE     = 7,
    parameter int unsigned LEFT_BOUND    = 16,
    parameter int unsigned RIGHT_BOUND   = 624,
    parameter int unsigned TOP_BOUND     = 40,
    parameter int unsigned BOTTOM_BOUND  = 464,
    parameter int unsigned PADDLE_WIDTH  = 8,
    parameter int unsigned PADDLE_HEIGHT = 60,
    parameter int unsigned BALL_RADIUS   = 4,
    parameter int unsigned SPEED_H       = 3,
    parameter int unsigned SPEED_V       = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pause,
    input  logic [9:0] p1_pos_v,
    input  logic [9:0] p2_pos_v,
    output logic [9:0] ball_pos_h,
    output logic [9:0] ball_pos_v,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic       game_over,
    output logic       hit_p1,
    output logic       hit_p2,
    output logic       point_p1,
    output logic       point_p2
);

    // ------------------------------------------------------------------------
    // Derived constants. The comparisons are done 11 bits wide and are
    // written as additions only, so no intermediate value can underflow.
    // ------------------------------------------------------------------------
    localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SC_W  = $clog2(SERVE_TICKS + 1);

    localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(TICK_DIV - 1);
    localparam logic [SC_W-1:0]  SERVE_MAX = SC_W'(SERVE_TICKS - 1);

    localparam logic [10:0] C_CH   = 11'((LEFT_BOUND + RIGHT_BOUND) / 2);
    localparam logic [10:0] C_CV   = 11'((TOP_BOUND + BOTTOM_BOUND) / 2);
    localparam logic [10:0] C_LF   = 11'(LEFT_BOUND + PADDLE_WIDTH);
    localparam logic [10:0] C_RF   = 11'(RIGHT_BOUND - PADDLE_WIDTH);
    localparam logic [10:0] C_R    = 11'(BALL_RADIUS);
    localparam logic [10:0] C_SH   = 11'(SPEED_H);
    localparam logic [10:0] C_SV   = 11'(SPEED_V);
    localparam logic [10:0] C_TOP  = 11'(TOP_BOUND);
    localparam logic [10:0] C_BOT  = 11'(BOTTOM_BOUND);
    localparam logic [10:0] C_PHR  = 11'(PADDLE_HEIGHT + BALL_RADIUS);

    // Rest positions after a wall or paddle bounce.
    localparam logic [10:0] C_V_BOT_REST = 11'(BOTTOM_BOUND - BALL_RADIUS);
    localparam logic [10:0] C_V_TOP_REST = 11'(TOP_BOUND + BALL_RADIUS);
    localparam logic [10:0] C_H_RGT_REST = 11'(RIGHT_BOUND - PADDLE_WIDTH - BALL_RADIUS);
    localparam logic [10:0] C_H_LFT_REST = 11'(LEFT_BOUND + PADDLE_WIDTH + BALL_RADIUS);

    localparam logic [3:0] WIN = 4'(WIN_SCORE);

    typedef enum logic [1:0] {
        ST_SERVE     = 2'd0,
        ST_PLAY      = 2'd1,
        ST_GAME_OVER = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    state_t           state_q;
    logic [DIV_W-1:0] div_q;
    logic [SC_W-1:0]  serve_cnt_q;
    logic [9:0]       h_q;
    logic [9:0]       v_q;
    logic             dir_h_q;
    logic             dir_v_q;
    logic [3:0]       score1_q;
    logic [3:0]       score2_q;
    logic             game_over_q;
    logic             hit1_q;
    logic             hit2_q;
    logic             point1_q;
    logic             point2_q;

    // ------------------------------------------------------------------------
    // Tick generation. The divider free-runs; pause only masks the tick.
    // ------------------------------------------------------------------------
    logic tick;
    assign tick = (div_q == DIV_MAX) && !pause;

    // ------------------------------------------------------------------------
    // Physics for one PLAY tick, evaluated on the pre-tick position.
    // ------------------------------------------------------------------------
    logic [10:0] h_w;
    logic [10:0] v_w;
    logic [10:0] p1_w;
    logic [10:0] p2_w;

    assign h_w  = {1'b0, h_q};
    assign v_w  = {1'b0, v_q};
    assign p1_w = {1'b0, p1_pos_v};
    assign p2_w = {1'b0, p2_pos_v};

    logic       bot_hit;
    logic       top_hit;
    logic       right_edge;
    logic       left_edge;
    logic       p1_overlap;
    logic       p2_overlap;
    logic       miss_right;
    logic       miss_left;
    logic [9:0] v_d;
    logic       dir_v_d;
    logic [9:0] h_d;
    logic       dir_h_d;
    logic       hit1_d;
    logic       hit2_d;

    always_comb begin
        bot_hit    = dir_v_q  && ((v_w + C_R + C_SV) >= C_BOT);
        top_hit    = !dir_v_q && (v_w <= (C_TOP + C_R + C_SV));
        right_edge = dir_h_q  && ((h_w + C_R + C_SH) >= C_RF);
        left_edge  = !dir_h_q && (h_w <= (C_LF + C_R + C_SH));

        // Ball overlaps a paddle if its vertical extent touches the paddle
        // span; expressed with additions on both sides.
        p1_overlap = ((v_w + C_R) >= p1_w) && (v_w <= (p1_w + C_PHR));
        p2_overlap = ((v_w + C_R) >= p2_w) && (v_w <= (p2_w + C_PHR));

        miss_right = right_edge && !p2_overlap;
        miss_left  = left_edge  && !p1_overlap;

        // Vertical update
        v_d     = v_q;
        dir_v_d = dir_v_q;
        if (bot_hit) begin
            v_d     = C_V_BOT_REST[9:0];
            dir_v_d = 1'b0;
        end else if (top_hit) begin
            v_d     = C_V_TOP_REST[9:0];
            dir_v_d = 1'b1;
        end else if (dir_v_q) begin
            v_d = v_q + C_SV[9:0];
        end else begin
            // Safe: not at the top wall means v > TOP+R+SPEED_V.
            v_d = v_q - C_SV[9:0];
        end

        // Horizontal update. The miss cases are handled by the FSM, which
        // ignores these values when a miss occurs.
        h_d     = h_q;
        dir_h_d = dir_h_q;
        hit1_d  = 1'b0;
        hit2_d  = 1'b0;
        if (right_edge) begin
            if (p2_overlap) begin
                h_d     = C_H_RGT_REST[9:0];
                dir_h_d = 1'b0;
                hit2_d  = 1'b1;
            end
        end else if (left_edge) begin
            if (p1_overlap) begin
                h_d     = C_H_LFT_REST[9:0];
                dir_h_d = 1'b1;
                hit1_d  = 1'b1;
            end
        end else if (dir_h_q) begin
            h_d = h_q + C_SH[9:0];
        end else begin
            h_d = h_q - C_SH[9:0];
        end
    end

    // ------------------------------------------------------------------------
    // Game FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_SERVE;
            div_q       <= '0;
            serve_cnt_q <= '0;
            h_q         <= C_CH[9:0];
            v_q         <= C_CV[9:0];
            dir_h_q     <= 1'b1;
            dir_v_q     <= 1'b1;
            score1_q    <= 4'd0;
            score2_q    <= 4'd0;
            game_over_q <= 1'b0;
            hit1_q      <= 1'b0;
            hit2_q      <= 1'b0;
            point1_q    <= 1'b0;
            point2_q    <= 1'b0;
        end else begin
            // Pulses last one clock unless re-armed by this tick.
            hit1_q   <= 1'b0;
            hit2_q   <= 1'b0;
            point1_q <= 1'b0;
            point2_q <= 1'b0;

            if (div_q == DIV_MAX) begin
                div_q <= '0;
            end else begin
                div_q <= div_q + 1'b1;
            end

            if (tick) begin
                case (state_q)
                    ST_SERVE: begin
                        h_q <= C_CH[9:0];
                        v_q <= C_CV[9:0];
                        if (serve_cnt_q == SERVE_MAX) begin
                            serve_cnt_q <= '0;
                            state_q     <= ST_PLAY;
                        end else begin
                            serve_cnt_q <= serve_cnt_q + 1'b1;
                        end
                    end

                    ST_PLAY: begin
                        if (miss_right) begin
                            // Player 1 scores; relaunch toward player 2.
                            score1_q <= score1_q + 4'd1;
                            point1_q <= 1'b1;
                            h_q      <= C_CH[9:0];
                            v_q      <= C_CV[9:0];
                            dir_h_q  <= 1'b1;
                            dir_v_q  <= ~dir_v_q;
                            if ((score1_q + 4'd1) == WIN) begin
                                state_q     <= ST_GAME_OVER;
                                game_over_q <= 1'b1;
                            end else begin
                                state_q <= ST_SERVE;
                            end
                        end else if (miss_left) begin
                            // Player 2 scores; relaunch toward player 1.
                            score2_q <= score2_q + 4'd1;
                            point2_q <= 1'b1;
                            h_q      <= C_CH[9:0];
                            v_q      <= C_CV[9:0];
                            dir_h_q  <= 1'b0;
                            dir_v_q  <= ~dir_v_q;
                            if ((score2_q + 4'd1) == WIN) begin
                                state_q     <= ST_GAME_OVER;
                                game_over_q <= 1'b1;
                            end else begin
                                state_q <= ST_SERVE;
                            end
                        end else begin
                            h_q     <= h_d;
                            dir_h_q <= dir_h_d;
                            v_q     <= v_d;
                            dir_v_q <= dir_v_d;
                            hit1_q  <= hit1_d;
                            hit2_q  <= hit2_d;
                        end
                    end

                    ST_GAME_OVER: begin
                        // Frozen until reset.
                        game_over_q <= 1'b1;
                    end

                    default: begin
                        state_q <= ST_SERVE;
                    end
                endcase
            end
        end
    end

    assign ball_pos_h = h_q;
    assign ball_pos_v = v_q;
    assign score_p1   = score1_q;
    assign score_p2   = score2_q;
    assign game_over  = game_over_q;
    assign hit_p1     = hit1_q;
    assign hit_p2     = hit2_q;
    assign point_p1   = point1_q;
    assign point_p2   = point2_q;

endmodule
